// File: rtl/alu_exec_if.sv
// alu_exec_if: operation/result bundle between the decode stage and alu_exec_unit.
//   master (decode side): drives in_valid, aluCont, psrWrEn, cond, dst, src;
//                         observes in_ready, result, out_valid, psr, busy.
//   slave  (execute side): the reverse.
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       aluCont;
    logic [4:0]       psrWrEn;
    logic [3:0]       cond;
    logic [WIDTH-1:0] dst;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic [4:0]       psr;
    logic             busy;

    modport master (
        output in_valid, aluCont, psrWrEn, cond, dst, src,
        input  in_ready, result, out_valid, psr, busy
    );

    modport slave (
        input  in_valid, aluCont, psrWrEn, cond, dst, src,
        output in_ready, result, out_valid, psr, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: executes one ALU decode word per accepted operation and owns
// the processor status register {C,L,F,Z,N}.
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    alu_exec_if.slave: in_valid/in_ready handshake, aluCont, psrWrEn,
//          cond, dst, src in; registered result, out_valid pulse, psr, busy out.
// Single-cycle ops retire at the accept edge. MUL is a 16-step shift-add that
// stalls the input side until its result lands.
//
// state  | meaning
// S_IDLE | accepting; single-cycle ops retire directly from here
// S_MUL  | shift-add multiply in progress, input stalled
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    alu_exec_if.slave bus
);
    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_MUL   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_OR    = 5'b00100;
    localparam logic [4:0] OP_XOR   = 5'b00101;
    localparam logic [4:0] OP_XNOR  = 5'b00110;
    localparam logic [4:0] OP_SCOND = 5'b00111;
    localparam logic [4:0] OP_MOV   = 5'b01000;
    localparam logic [4:0] OP_LUI   = 5'b01001;
    localparam logic [4:0] OP_NOT   = 5'b01010;
    localparam logic [4:0] OP_LSH   = 5'b01011;
    localparam logic [4:0] OP_LSHL  = 5'b01100;
    localparam logic [4:0] OP_LSHR  = 5'b01101;
    localparam logic [4:0] OP_ASHU  = 5'b01110;
    localparam logic [4:0] OP_ASHR  = 5'b01111;
    localparam logic [4:0] OP_BCOND = 5'b10000;
    localparam logic [4:0] OP_JCOND = 5'b10001;

    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [4:0]       mask_q, mask_d;
    logic             mul_l_q, mul_l_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       psr_q, psr_d;

    logic [WIDTH-1:0] dst, src;
    logic [WIDTH:0]   sum_w, diff_w;
    logic             lt_u, lt_s, ovf_add, ovf_sub;
    logic             cond_true, op_known;
    logic [3:0]       amt4_pos, amt4_neg;
    logic [4:0]       amt5_neg;
    logic [WIDTH-1:0] op_result, acc_step;
    logic [4:0]       op_flags, mul_flags;

    assign dst = bus.dst;
    assign src = bus.src;

    assign sum_w   = {1'b0, dst} + {1'b0, src};
    assign diff_w  = {1'b0, dst} - {1'b0, src};
    assign lt_u    = diff_w[WIDTH];
    assign lt_s    = $signed(dst) < $signed(src);
    assign ovf_add = (dst[MSB] == src[MSB]) && (sum_w[MSB] != dst[MSB]);
    assign ovf_sub = (dst[MSB] != src[MSB]) && (diff_w[MSB] != dst[MSB]);

    // Low bits of (-src) depend only on the low bits of src.
    assign amt4_pos = src[3:0];
    assign amt4_neg = 4'd0 - src[3:0];
    assign amt5_neg = 5'd0 - src[4:0];

    // psr bit order {C,L,F,Z,N}
    always_comb begin
        cond_true = 1'b0;
        case (bus.cond)
            4'b0000: cond_true =  psr_q[1];
            4'b0001: cond_true = !psr_q[1];
            4'b0010: cond_true =  psr_q[4];
            4'b0011: cond_true = !psr_q[4];
            4'b0100: cond_true =  psr_q[3];
            4'b0101: cond_true = !psr_q[3];
            4'b0110: cond_true =  psr_q[0];
            4'b0111: cond_true = !psr_q[0];
            4'b1000: cond_true =  psr_q[2];
            4'b1001: cond_true = !psr_q[2];
            4'b1010: cond_true = !psr_q[3] && !psr_q[1];
            4'b1011: cond_true =  psr_q[3] ||  psr_q[1];
            4'b1100: cond_true = !psr_q[0] && !psr_q[1];
            4'b1101: cond_true =  psr_q[0] ||  psr_q[1];
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        op_result = '0;
        op_known  = 1'b1;
        case (bus.aluCont)
            OP_ADD:   op_result = sum_w[MSB:0];
            OP_SUB:   op_result = diff_w[MSB:0];
            OP_AND:   op_result = dst & src;
            OP_OR:    op_result = dst | src;
            OP_XOR:   op_result = dst ^ src;
            OP_XNOR:  op_result = ~(dst ^ src);
            OP_SCOND: op_result = {{(WIDTH-1){1'b0}}, cond_true};
            OP_MOV:   op_result = src;
            OP_LUI:   op_result = {src[WIDTH/2-1:0], dst[WIDTH/2-1:0]};
            OP_NOT:   op_result = ~dst;
            OP_LSH:   op_result = src[MSB] ? (dst >> amt4_neg) : (dst << amt4_pos);
            OP_LSHL:  op_result = dst << amt4_pos;
            OP_LSHR:  op_result = dst >> amt5_neg;
            OP_ASHU:  op_result = src[MSB] ? WIDTH'($signed(dst) >>> amt4_neg)
                                           : (dst << amt4_pos);
            OP_ASHR:  op_result = WIDTH'($signed(dst) >>> amt5_neg);
            OP_BCOND: op_result = cond_true ? sum_w[MSB:0] : dst;
            OP_JCOND: op_result = cond_true ? src : dst;
            default:  op_known  = 1'b0;
        endcase
    end

    // Outside add/sub, C and F have no meaning and are written as 0; L is
    // always the unsigned compare of the operands.
    always_comb begin
        op_flags = {1'b0, lt_u, 1'b0, (op_result == '0), op_result[MSB]};
        if (bus.aluCont == OP_ADD) begin
            op_flags = {sum_w[WIDTH], lt_u, ovf_add, (op_result == '0), op_result[MSB]};
        end else if (bus.aluCont == OP_SUB) begin
            op_flags = {lt_u, lt_u, ovf_sub, (op_result == '0), lt_s};
        end
    end

    assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_flags = {1'b0, mul_l_q, 1'b0, (acc_step == '0), acc_step[MSB]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mask_d      = mask_q;
        mul_l_d     = mul_l_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        psr_d       = psr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.aluCont == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = 4'd15;
                        acc_d    = '0;
                        mcand_d  = dst;
                        mplier_d = src;
                        mask_d   = bus.psrWrEn;
                        mul_l_d  = lt_u;
                    end else begin
                        result_d    = op_result;
                        out_valid_d = 1'b1;
                        if (op_known) begin
                            psr_d = (psr_q & ~bus.psrWrEn) | (op_flags & bus.psrWrEn);
                        end
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d     = S_IDLE;
                    result_d    = acc_step;
                    out_valid_d = 1'b1;
                    psr_d       = (psr_q & ~mask_q) | (mul_flags & mask_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mask_q      <= '0;
            mul_l_q     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            psr_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mask_q      <= mask_d;
            mul_l_q     <= mul_l_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            psr_q       <= psr_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_MUL);
    assign bus.result    = result_q;
    assign bus.out_valid = out_valid_q;
    assign bus.psr       = psr_q;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the ALU decode word: takes an aluCont opcode, a psrWrEn flag mask, a condition code and two operands, and produces a registered result.
- Owns the processor status register (PSR: C, L, F, Z, N).
- Single-cycle ops complete with latency 1. MUL runs an iterative shift-add sequencer; in_ready is low while it runs.

Parameters:
- WIDTH, 16: datapath width. Shift-amount rules below assume 16.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  unit can accept an operation; an operation is accepted when in_valid and in_ready are both high.
- aluCont  in  5  operation select.
- psrWrEn  in  5  flag write mask; bits {4:C, 3:L, 2:F, 1:Z, 0:N}.
- cond  in  4  condition code for Scond/Bcond/Jcond.
- dst  in  WIDTH  destination operand.
- src  in  WIDTH  source operand.
- result  out  WIDTH  registered result.
- out_valid  out  1  one-cycle pulse; result is valid.
- psr  out  5  current flags {C,L,F,Z,N}.
- busy  out  1  MUL in progress.

Behaviour:
- Reset (reset=0 at a clk edge): result=0, out_valid=0, psr=0, busy=0, state=IDLE. Reset mid-MUL aborts the operation with no out_valid. in_ready=1 once reset is released.
- States:
  - IDLE: in_ready=1. Accepting a non-MUL op goes back to IDLE; accepting MUL (aluCont=00010) goes to MUL.
  - MUL: in_ready=0, busy=1. 16 iterations (count 15 down to 0), then go to IDLE.
  - No backpressure on the output side.
- Single-cycle ops: result and the PSR update are registered at the accept edge; out_valid=1 during the following cycle only.
  - Back-to-back accepts every cycle are legal.
  - Each op's cond sees the PSR as written by the previous op.
- MUL:
  - Operands are latched at accept.
  - result = low WIDTH bits of dst*src (unsigned shift-add).
  - The result and masked PSR write land at the 16th edge after accept; out_valid is asserted the cycle after that edge (accept-to-out_valid latency 17 cycles).
  - in_ready returns to 1 in that same out_valid cycle.
- aluCont encodings:
  - 00000: dst+src
  - 00001: dst-src
  - 00010: MUL
  - 00011: and
  - 00100: or
  - 00101: xor
  - 00110: ~(dst^src)
  - 00111: Scond, result = {15'b0, condTrue}
  - 01000: src
  - 01001: {src[7:0], dst[7:0]}
  - 01010: ~dst
  - 01011: LSH. If src negative: dst >> (-src)[3:0], logical; else dst << src[3:0].
  - 01100: dst << src[3:0]
  - 01101: dst >> (-src)[4:0], logical
  - 01110: ASHU. Same as LSH but the right shift is arithmetic.
  - 01111: dst >>> (-src)[4:0]
  - 10000: condTrue ? dst+src : dst
  - 10001: condTrue ? src : dst
  - All other codes: result 0, no PSR change.
  - Shift amounts of 16 or more give 0 for logical shifts and the sign fill for arithmetic shifts.
- Flags, each written only if its psrWrEn bit is 1:
  - C: carry out of add; borrow (dst<src unsigned) for sub.
  - L: dst<src unsigned.
  - F: signed overflow of the add or sub.
  - Z: result==0.
  - N: result[15] for add/sub, signed dst<src for sub.
  - For logic ops only Z is meaningful; the decode enables Z only.
- condTrue:
  - 0000 Z
  - 0001 !Z
  - 0010 C
  - 0011 !C
  - 0100 L
  - 0101 !L
  - 0110 N
  - 0111 !N
  - 1000 F
  - 1001 !F
  - 1010 !L&!Z
  - 1011 L|Z
  - 1100 !N&!Z
  - 1101 N|Z
  - 1110 1
  - 1111 0
- in_valid while in_ready=0 is ignored: no accept, no state change.

Test Plan:
- Reset, then add, psrWrEn=10111, dst=FFFF, src=0001 -> out_valid after 1 cycle, result=0000, psr: C=1, F=0, Z=1, N=0, L unchanged (0).
- Sub, psrWrEn=01011, dst=0003, src=0005 -> L=1, Z=0, N=1, C unchanged. Next cycle Scond cond=0100 -> result=0001.
- MUL dst=0123, src=0010 -> in_ready low 16 cycles, busy=1; an in_valid add issued during MUL is ignored; out_valid at cycle 17 with result=1230; an add accepted in that cycle completes normally.
- ASHU dst=8000, src=FFFC (-4) -> F800. LSH same operands -> 0800. LSHI-left dst=0001, src=000F -> 8000.
- Bcond cond=0000 with Z=1, dst=0100, src=0010 -> 0110. With Z=0 -> 0100. Jcond cond=1110 -> src.
- Reset asserted at MUL cycle 8 -> no out_valid, psr=0, in_ready=1 after release.
